systolic_result_streamer: RTL and testbench
===========================================

// Module: systolic_result_streamer
// PURPOSE
//  Downstream consumer of the 3x3 systolic multiplier top (systolic_3x3_top).
//  Detects the rising edge of its done flag and snapshots the nine result
//  words c00..c22 into a local buffer. Streams them out one word per
//  handshake over a valid/ready interface, with a last marker, to the result
//  sink (UART/DMA packer). Counts frames and flags results lost while busy.
// PARAMETERS
//  DATA_W     16  width of each result word (matches c00..c22)
//  COL_MAJOR  0   0: emit row-major c00,c01,c02,c10..c22; 1: column-major c00,c10,c20,c01..c22
// PORTS
//  clk         in   1         system clock, all logic on rising edge
//  rst         in   1         synchronous, active-high reset
//  done        in   1         multiplier done (level; rising edge = new result)
//  c00..c22    in   DATA_W x9 multiplier results, valid when done is high
//  out_data    out  DATA_W    current result word
//  out_index   out  4         matrix position of out_data, always r*3+c (0..8)
//  out_valid   out  1         out_data/out_index/out_last valid
//  out_ready   in   1         sink accepts the word when out_valid&out_ready
//  out_last    out  1         high with the 9th word of a frame
//  busy        out  1         high while in STREAM
//  drop_err    out  1         sticky: a result edge arrived and was dropped
//  frame_cnt   out  8         frames fully transmitted, wraps 255->0
// BEHAVIOUR
//  - Reset (rst=1 at clk edge): state=IDLE, out_valid=0, out_last=0, busy=0,
//    drop_err=0, frame_cnt=0, out_index=0, out_data=0, elem ptr=0,
//    done_q=1 (done held high across reset release does NOT trigger a frame).
//    Reset mid-stream aborts the frame; nothing further is emitted.
//  - Edge detect: ev = done & ~done_q; done_q <= done every cycle.
//  - States: IDLE, STREAM.
//    IDLE: on ev, latch all nine c inputs into buffer, ptr<=0, ->STREAM.
//      out_valid rises the cycle after ev (1-cycle latency).
//    STREAM: out_valid=1, busy=1; word = buf[seq(ptr)], seq per COL_MAJOR;
//      out_index = r*3+c of that word; out_last = (ptr==8).
//      On out_valid&out_ready: if ptr==8 -> frame_cnt+=1, IDLE (out_valid low
//      next cycle); else ptr+=1.
//  - out_data/out_index/out_last held stable while out_valid & ~out_ready;
//    buffer never changes during a frame.
//  - ev in STREAM without final handshake: dropped, drop_err<=1 (sticky
//    until rst); frame in progress unaffected.
//  - ev in same cycle as final (ptr==8) handshake: accepted, not dropped;
//    new buffer latched, ptr<=0, stay STREAM, frame_cnt+=1, out_valid stays 1
//    (back-to-back frames, no bubble).
//  - out_ready=1 continuously: 9 words in 9 consecutive cycles.
//  - out_ready ignored when out_valid=0. No arithmetic on data; widths
//    passed unmodified.
// TESTING
//  1 Reset: rst high 2 cycles, done=1 throughout, release -> no out_valid
//    for 5 cycles, frame_cnt=0, drop_err=0.
//  2 c = 1..9 row-major (I x [1..9]), done pulse, out_ready=1 -> words 1..9
//    on 9 consecutive cycles, out_index 0..8, out_last only on 9, frame_cnt=1.
//  3 COL_MAJOR=1, same inputs -> words 1,4,7,2,5,8,3,6,9; out_index
//    0,3,6,1,4,7,2,5,8.
//  4 Backpressure: out_ready toggles 1,0,0,1... -> no word lost/duplicated,
//    data stable during stall; inputs changed mid-frame do not alter output.
//  5 Second done edge at ptr=3 -> ignored, drop_err=1, frame completes 1..9;
//    second edge coincident with final handshake -> next frame starts next
//    cycle with new values, drop_err unchanged.
//  6 rst asserted at ptr=4 -> out_valid=0 next cycle, frame_cnt=0; 256
//    frames -> frame_cnt wraps to 0.

Source files
------------

// File: rtl/systolic_result_streamer.sv
// systolic_result_streamer
// Captures the nine result words of the 3x3 systolic multiplier on the rising
// edge of its done flag. It then streams them out one word per valid/ready
// handshake and marks the ninth word of each frame with out_last.
// Completed frames are counted. A result edge that arrives while a frame is
// still in flight is dropped, and drop_err records that it happened.
module systolic_result_streamer #(
  parameter int DATA_W    = 16,
  parameter bit COL_MAJOR = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              done,
  input  logic [DATA_W-1:0] c00,
  input  logic [DATA_W-1:0] c01,
  input  logic [DATA_W-1:0] c02,
  input  logic [DATA_W-1:0] c10,
  input  logic [DATA_W-1:0] c11,
  input  logic [DATA_W-1:0] c12,
  input  logic [DATA_W-1:0] c20,
  input  logic [DATA_W-1:0] c21,
  input  logic [DATA_W-1:0] c22,
  output logic [DATA_W-1:0] out_data,
  output logic [3:0]        out_index,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              drop_err,
  output logic [7:0]        frame_cnt
);

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  state_t            state;
  logic              done_q;
  logic [3:0]        ptr;
  logic [3:0]        ptr_nxt;
  logic [DATA_W-1:0] cin     [9];
  logic [DATA_W-1:0] res_buf [9];
  logic              ev;
  logic              fire;
  logic              final_fire;
  logic              load;

  // Maps the emission slot (0..8) to the row-major matrix position r*3+c.
  function automatic logic [3:0] pos_of(input logic [3:0] p);
    logic [3:0] pos;
    if (!COL_MAJOR) begin
      pos = p;
    end else begin
      case (p)
        4'd0:    pos = 4'd0;
        4'd1:    pos = 4'd3;
        4'd2:    pos = 4'd6;
        4'd3:    pos = 4'd1;
        4'd4:    pos = 4'd4;
        4'd5:    pos = 4'd7;
        4'd6:    pos = 4'd2;
        4'd7:    pos = 4'd5;
        4'd8:    pos = 4'd8;
        default: pos = 4'd0;
      endcase
    end
    return pos;
  endfunction

  // Gathers the result ports into a row-major array, and derives the edge, handshake and load strobes.
  always_comb begin
    cin[0]     = c00;
    cin[1]     = c01;
    cin[2]     = c02;
    cin[3]     = c10;
    cin[4]     = c11;
    cin[5]     = c12;
    cin[6]     = c20;
    cin[7]     = c21;
    cin[8]     = c22;
    ev         = done & ~done_q;
    fire       = out_valid & out_ready;
    final_fire = fire & (ptr == 4'd8);
    load       = ev & ((state == IDLE) | final_fire);
    ptr_nxt    = ptr + 4'd1;
  end

  // The snapshot buffer changes only when a new frame is accepted, so it is frozen while a frame streams out.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 9; i++) begin
        res_buf[i] <= cin[i];
      end
    end
  end

  // Main controller: edge detection, frame sequencing, registered stream outputs and status.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      done_q    <= 1'b1;
      ptr       <= 4'd0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_index <= 4'd0;
      out_data  <= '0;
      busy      <= 1'b0;
      drop_err  <= 1'b0;
      frame_cnt <= 8'd0;
    end else begin
      done_q <= done;
      unique case (state)
        IDLE: begin
          if (ev) begin
            state     <= STREAM;
            ptr       <= 4'd0;
            out_valid <= 1'b1;
            busy      <= 1'b1;
            out_last  <= 1'b0;
            out_index <= pos_of(4'd0);
            out_data  <= cin[pos_of(4'd0)];
          end
        end
        STREAM: begin
          if (ev && !final_fire) begin
            drop_err <= 1'b1;
          end
          if (final_fire) begin
            frame_cnt <= frame_cnt + 8'd1;
            if (ev) begin
              ptr       <= 4'd0;
              out_last  <= 1'b0;
              out_index <= pos_of(4'd0);
              out_data  <= cin[pos_of(4'd0)];
            end else begin
              state     <= IDLE;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              out_last  <= 1'b0;
            end
          end else if (fire) begin
            ptr       <= ptr_nxt;
            out_last  <= (ptr_nxt == 4'd8);
            out_index <= pos_of(ptr_nxt);
            out_data  <= res_buf[pos_of(ptr_nxt)];
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          out_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_result_streamer.sv
// tb_systolic_result_streamer
// Drives a row-major and a column-major instance with the same inputs.
// Both instances are compared each cycle against a frame-level reference model.
module tb_systolic_result_streamer;

  logic        clk = 1'b0;
  logic        rst;
  logic        done;
  logic        out_ready;
  logic [15:0] cv [9];

  logic [15:0] od [2];
  logic [3:0]  oi [2];
  logic        ov [2];
  logic        ol [2];
  logic        ob [2];
  logic        oe [2];
  logic [7:0]  of [2];

  int checks = 0;
  int errors = 0;

  // Reference model state: the captured frame, the words already sent and the status values.
  bit          m_active;
  int          m_k;
  logic [15:0] m_frame [9];
  logic [7:0]  m_frames;
  bit          m_drop;
  bit          m_done_prev;

  always #5 clk = ~clk;

  systolic_result_streamer #(.DATA_W(16), .COL_MAJOR(1'b0)) dut_row (
    .clk(clk), .rst(rst), .done(done),
    .c00(cv[0]), .c01(cv[1]), .c02(cv[2]), .c10(cv[3]), .c11(cv[4]),
    .c12(cv[5]), .c20(cv[6]), .c21(cv[7]), .c22(cv[8]),
    .out_data(od[0]), .out_index(oi[0]), .out_valid(ov[0]), .out_ready(out_ready),
    .out_last(ol[0]), .busy(ob[0]), .drop_err(oe[0]), .frame_cnt(of[0])
  );

  systolic_result_streamer #(.DATA_W(16), .COL_MAJOR(1'b1)) dut_col (
    .clk(clk), .rst(rst), .done(done),
    .c00(cv[0]), .c01(cv[1]), .c02(cv[2]), .c10(cv[3]), .c11(cv[4]),
    .c12(cv[5]), .c20(cv[6]), .c21(cv[7]), .c22(cv[8]),
    .out_data(od[1]), .out_index(oi[1]), .out_valid(ov[1]), .out_ready(out_ready),
    .out_last(ol[1]), .busy(ob[1]), .drop_err(oe[1]), .frame_cnt(of[1])
  );

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advances the model by one clock edge, using the inputs the DUTs saw at that edge.
  task automatic modelUpdate();
    bit ev;
    bit was_active;
    bit last_hs;
    if (rst) begin
      m_active    = 0;
      m_k         = 0;
      m_frames    = 8'd0;
      m_drop      = 0;
      m_done_prev = 1;
      return;
    end
    ev          = done && !m_done_prev;
    m_done_prev = done;
    was_active  = m_active;
    last_hs     = m_active && out_ready && (m_k == 8);
    if (m_active && out_ready) begin
      if (m_k == 8) begin
        m_frames = m_frames + 8'd1;
        m_active = 0;
      end else begin
        m_k++;
      end
    end
    if (ev) begin
      if (!was_active || last_hs) begin
        for (int i = 0; i < 9; i++) m_frame[i] = cv[i];
        m_k      = 0;
        m_active = 1;
      end else begin
        m_drop = 1;
      end
    end
  endtask

  task automatic checkOutput();
    int pos;
    for (int d = 0; d < 2; d++) begin
      checkValue($sformatf("d%0d_valid", d), 32'(ov[d]), 32'(m_active));
      checkValue($sformatf("d%0d_busy", d), 32'(ob[d]), 32'(m_active));
      checkValue($sformatf("d%0d_drop_err", d), 32'(oe[d]), 32'(m_drop));
      checkValue($sformatf("d%0d_frame_cnt", d), 32'(of[d]), 32'(m_frames));
      if (m_active) begin
        pos = (d == 0) ? m_k : ((m_k % 3) * 3 + m_k / 3);
        checkValue($sformatf("d%0d_data_k%0d", d, m_k), 32'(od[d]), 32'(m_frame[pos]));
        checkValue($sformatf("d%0d_index_k%0d", d, m_k), 32'(oi[d]), pos);
        checkValue($sformatf("d%0d_last_k%0d", d, m_k), 32'(ol[d]), 32'(m_k == 8));
      end
    end
  endtask

  task automatic applyStimulus(input bit r, input bit d, input bit rdy);
    rst       = r;
    done      = d;
    out_ready = rdy;
    @(posedge clk);
    modelUpdate();
    #1;
    checkOutput();
  endtask

  task automatic randomizeC();
    for (int i = 0; i < 9; i++) cv[i] = 16'($urandom);
  endtask

  initial begin
    int budget;
    rst = 1'b1; done = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 9; i++) cv[i] = 16'(i + 1);
    m_active = 0; m_k = 0; m_frames = 8'd0; m_drop = 0; m_done_prev = 1;
    for (int i = 0; i < 9; i++) m_frame[i] = 16'd0;

    // Reset with done held high must not start a frame after release.
    $display("[TB] reset with done held high");
    applyStimulus(1, 1, 1);
    applyStimulus(1, 1, 1);
    checkValue("rst_index", 32'(oi[0]), 0);
    checkValue("rst_data", 32'(od[0]), 0);
    checkValue("rst_last", 32'(ol[0]), 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 1);
    checkValue("rst_valid_after5", 32'(ov[0]), 0);
    checkValue("rst_frame_cnt", 32'(of[0]), 0);

    // Values 1..9 with full throughput.
    $display("[TB] single frame, values 1..9");
    applyStimulus(0, 0, 1);
    applyStimulus(0, 1, 1);
    checkValue("first_word_row", 32'(od[0]), 1);
    checkValue("first_word_col", 32'(od[1]), 1);
    applyStimulus(0, 0, 1);
    checkValue("second_word_row", 32'(od[0]), 2);
    checkValue("second_word_col", 32'(od[1]), 4);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 1);
    checkValue("frame1_cnt", 32'(of[0]), 1);

    // Backpressure with a 1,0,0 ready pattern, while the inputs change under the frame.
    $display("[TB] backpressure");
    randomizeC();
    applyStimulus(0, 1, 0);
    for (int i = 0; i < 40; i++) begin
      randomizeC();
      applyStimulus(0, 0, (i % 3) == 0);
    end
    checkValue("bp_cnt", 32'(of[0]), 2);

    // A second edge mid-frame is dropped. An edge coincident with the final handshake chains a new frame.
    $display("[TB] overlapping done edges");
    randomizeC();
    applyStimulus(0, 1, 1);
    budget = 0;
    while (!(m_active && m_k == 3) && budget < 20) begin applyStimulus(0, 0, 1); budget++; end
    randomizeC();
    applyStimulus(0, 1, 1);
    checkValue("drop_set", 32'(oe[0]), 1);
    budget = 0;
    while (!(m_active && m_k == 8) && budget < 20) begin applyStimulus(0, 0, 1); budget++; end
    randomizeC();
    applyStimulus(0, 1, 1);
    checkValue("chain_valid", 32'(ov[0]), 1);
    checkValue("chain_first", 32'(od[0]), 32'(cv[0]));
    checkValue("chain_drop", 32'(oe[0]), 1);
    for (int i = 0; i < 12; i++) applyStimulus(0, 0, 1);
    checkValue("chain_cnt", 32'(of[0]), 4);

    // Random done pulses and ready.
    $display("[TB] random traffic");
    for (int i = 0; i < 300; i++) begin
      randomizeC();
      applyStimulus(0, ($urandom % 6) == 0, ($urandom % 3) != 0);
    end

    // A reset in the middle of a frame aborts it.
    $display("[TB] reset mid-frame");
    applyStimulus(0, 0, 1);
    for (int i = 0; i < 12; i++) applyStimulus(0, 0, 1);
    randomizeC();
    applyStimulus(0, 1, 1);
    budget = 0;
    while (!(m_active && m_k == 4) && budget < 20) begin applyStimulus(0, 0, 1); budget++; end
    applyStimulus(1, 0, 1);
    checkValue("abort_valid", 32'(ov[0]), 0);
    checkValue("abort_cnt", 32'(of[0]), 0);
    applyStimulus(0, 0, 1);

    // Run 256 frames, so that frame_cnt wraps back to zero.
    $display("[TB] 256 frames");
    for (int f = 0; f < 256; f++) begin
      randomizeC();
      applyStimulus(0, 1, ($urandom % 4) != 0);
      budget = 0;
      while (m_active && budget < 60) begin
        applyStimulus(0, 0, ($urandom % 4) != 0);
        budget++;
      end
      checkValue("frame_timeout", 32'(budget < 60), 1);
    end
    checkValue("wrap_cnt", 32'(of[0]), 0);
    checkValue("wrap_cnt_col", 32'(of[1]), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
